// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: one-op-in-flight initiator for the clocked 16-bit ALU.
// Presents a command to the ALU, waits out its latency, captures the result
// and class flags, and returns them on a valid/ready response channel.
// Divide-by-zero requests are answered directly without touching the ALU.
module alu_op_sequencer #(
    parameter int                WIDTH      = 16,
    parameter int                ALU_LAT    = 1,
    parameter logic [WIDTH-1:0]  DIV0_VALUE = '1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [3:0]       cmd_fun,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic [3:0]       rsp_flags,
    output logic             rsp_flag_err,
    output logic             rsp_div0,
    output logic [15:0]      op_count,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_arith_flag,
    input  logic             alu_logic_flag,
    input  logic             alu_cmp_flag,
    input  logic             alu_shift_flag
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);
    localparam logic [3:0] FUN_IDLE = 4'hF;
    localparam logic [3:0] FUN_DIV  = 4'h3;

    // Flag pattern {Arith, Logic, Cmp, Shift} a healthy ALU raises per code.
    function automatic logic [3:0] class_flags(input logic [3:0] fun);
        if (fun <= 4'h3)      return 4'b1000;
        else if (fun <= 4'h9) return 4'b0100;
        else if (fun <= 4'hC) return 4'b0010;
        else if (fun <= 4'hE) return 4'b0001;
        else                  return 4'b0000;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_fun_q, alu_fun_d;
    logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_flag_err_q, rsp_flag_err_d;
    logic             rsp_div0_q, rsp_div0_d;
    logic [15:0]      op_count_q, op_count_d;
    logic [3:0]       flags_in;

    assign flags_in = {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag};

    // Next-state and next-output logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_fun_d      = alu_fun_q;
        rsp_out_d      = rsp_out_q;
        rsp_flags_d    = rsp_flags_q;
        rsp_flag_err_d = rsp_flag_err_q;
        rsp_div0_d     = rsp_div0_q;
        op_count_d     = op_count_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_fun == FUN_DIV && cmd_b == '0) begin
                        // Answer locally; the ALU stays parked on the idle code.
                        rsp_out_d      = DIV0_VALUE;
                        rsp_flags_d    = 4'b1000;
                        rsp_flag_err_d = 1'b0;
                        rsp_div0_d     = 1'b1;
                        state_d        = RESP;
                    end else begin
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        alu_fun_d = cmd_fun;
                        cnt_d     = LAT_INIT;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_out_d      = alu_out;
                    rsp_flags_d    = flags_in;
                    rsp_flag_err_d = (flags_in != class_flags(alu_fun_q));
                    rsp_div0_d     = 1'b0;
                    alu_a_d        = '0;
                    alu_b_d        = '0;
                    alu_fun_d      = FUN_IDLE;
                    state_d        = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and registered outputs; reset discards any in-flight op.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_fun_q      <= FUN_IDLE;
            rsp_out_q      <= '0;
            rsp_flags_q    <= 4'b0000;
            rsp_flag_err_q <= 1'b0;
            rsp_div0_q     <= 1'b0;
            op_count_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_fun_q      <= alu_fun_d;
            rsp_out_q      <= rsp_out_d;
            rsp_flags_q    <= rsp_flags_d;
            rsp_flag_err_q <= rsp_flag_err_d;
            rsp_div0_q     <= rsp_div0_d;
            op_count_q     <= op_count_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_out      = rsp_out_q;
    assign rsp_flags    = rsp_flags_q;
    assign rsp_flag_err = rsp_flag_err_q;
    assign rsp_div0     = rsp_div0_q;
    assign op_count     = op_count_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_fun      = alu_fun_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at ALU_LAT=1 for the
// functional vectors and one at ALU_LAT=4 for the mid-operation reset case.
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- instance at ALU_LAT = 1 ----------------
    logic        rst, cmd_valid, rsp_ready, fault_logic = 1'b0;
    logic [15:0] cmd_a, cmd_b;
    logic [3:0]  cmd_fun;
    logic        cmd_ready, rsp_valid, rsp_flag_err, rsp_div0;
    logic [15:0] rsp_out, op_count, alu_a, alu_b, alu_out;
    logic [3:0]  rsp_flags, alu_fun;
    logic        alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
    logic [15:0] exp_cnt;

    // ---------------- instance at ALU_LAT = 4 ----------------
    logic        rst4, cmd_valid4, rsp_ready4;
    logic [15:0] cmd_a4, cmd_b4;
    logic [3:0]  cmd_fun4;
    logic        cmd_ready4, rsp_valid4, rsp_flag_err4, rsp_div04;
    logic [15:0] rsp_out4, op_count4, alu_a4, alu_b4, alu_out4;
    logic [3:0]  rsp_flags4, alu_fun4;
    logic        alu_arith_flag4, alu_logic_flag4, alu_cmp_flag4, alu_shift_flag4;

    // Behavioural stand-in for the clocked ALU: {out[15:0], A, L, C, S}.
    function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] f, input logic fault);
        logic [15:0] o;
        logic [3:0]  fl;
        o = 16'h0; fl = 4'b0000;
        case (f)
            4'h0: begin o = a + b; fl = fault ? 4'b0100 : 4'b1000; end
            4'h1: begin o = a - b; fl = 4'b1000; end
            4'h2: begin o = a * b; fl = 4'b1000; end
            4'h3: begin o = (b != 16'h0) ? a / b : 16'h0; fl = 4'b1000; end
            4'h4: begin o = a & b; fl = 4'b0100; end
            4'h5: begin o = a | b; fl = 4'b0100; end
            4'h6: begin o = ~(a & b); fl = 4'b0100; end
            4'h7: begin o = ~(a | b); fl = 4'b0100; end
            4'h8: begin o = a ^ b; fl = 4'b0100; end
            4'h9: begin o = ~(a ^ b); fl = 4'b0100; end
            4'hA: begin o = {15'h0, a == b}; fl = 4'b0010; end
            4'hB: begin o = {15'h0, a > b}; fl = 4'b0010; end
            4'hC: begin o = {15'h0, a < b}; fl = 4'b0010; end
            4'hD: begin o = a >> 1; fl = 4'b0001; end
            4'hE: begin o = a << 1; fl = 4'b0001; end
            default: begin o = 16'h0; fl = 4'b0000; end
        endcase
        return {o, fl};
    endfunction

    logic [19:0] alu1_q;
    logic [19:0] alu4_q [4];

    always @(posedge clk) begin
        alu1_q   <= alu_model(alu_a, alu_b, alu_fun, fault_logic);
        alu4_q[0] <= alu_model(alu_a4, alu_b4, alu_fun4, 1'b0);
        for (int i = 1; i < 4; i++) alu4_q[i] <= alu4_q[i-1];
    end

    assign alu_out         = alu1_q[19:4];
    assign alu_arith_flag  = alu1_q[3];
    assign alu_logic_flag  = alu1_q[2];
    assign alu_cmp_flag    = alu1_q[1];
    assign alu_shift_flag  = alu1_q[0];
    assign alu_out4        = alu4_q[3][19:4];
    assign alu_arith_flag4 = alu4_q[3][3];
    assign alu_logic_flag4 = alu4_q[3][2];
    assign alu_cmp_flag4   = alu4_q[3][1];
    assign alu_shift_flag4 = alu4_q[3][0];

    alu_op_sequencer #(.WIDTH(16), .ALU_LAT(1)) dut (
        .CLK(clk), .RST(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags),
        .rsp_flag_err(rsp_flag_err), .rsp_div0(rsp_div0),
        .op_count(op_count),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_out(alu_out),
        .alu_arith_flag(alu_arith_flag), .alu_logic_flag(alu_logic_flag),
        .alu_cmp_flag(alu_cmp_flag), .alu_shift_flag(alu_shift_flag)
    );

    alu_op_sequencer #(.WIDTH(16), .ALU_LAT(4)) dut4 (
        .CLK(clk), .RST(rst4),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_fun(cmd_fun4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_out(rsp_out4), .rsp_flags(rsp_flags4),
        .rsp_flag_err(rsp_flag_err4), .rsp_div0(rsp_div04),
        .op_count(op_count4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_fun(alu_fun4),
        .alu_out(alu_out4),
        .alu_arith_flag(alu_arith_flag4), .alu_logic_flag(alu_logic_flag4),
        .alu_cmp_flag(alu_cmp_flag4), .alu_shift_flag(alu_shift_flag4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One op on the LAT=1 instance with rsp_ready held high.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                          input logic [15:0] exp_out, input logic [3:0] exp_fl,
                          input logic exp_err, input logic exp_div0);
        int lat;
        cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_valid = 1'b1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            chk("alu_fun_hold", 32'(alu_fun), exp_div0 ? 32'hF : 32'(fun));
            chk("alu_a_hold", 32'(alu_a), exp_div0 ? 32'h0 : 32'(a));
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_latency", 32'(lat), exp_div0 ? 32'd0 : 32'd2);
        chk("rsp_out", 32'(rsp_out), 32'(exp_out));
        chk("rsp_flags", 32'(rsp_flags), 32'(exp_fl));
        chk("rsp_flag_err", 32'(rsp_flag_err), 32'(exp_err));
        chk("rsp_div0", 32'(rsp_div0), 32'(exp_div0));
        chk("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        chk("alu_fun_resp", 32'(alu_fun), 32'hF);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    endtask

    logic [15:0] sweep_out [14] = '{16'h0000, 16'h0004, 16'h0001, 16'h0002, 16'h0002,
                                    16'hFFFD, 16'hFFFD, 16'h0000, 16'hFFFF, 16'h0001,
                                    16'h0000, 16'h0000, 16'h0001, 16'h0004};
    logic [3:0]  sweep_fl [14]  = '{4'h8, 4'h8, 4'h8, 4'h4, 4'h4, 4'h4, 4'h4,
                                    4'h4, 4'h4, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic        seen4;
        logic [15:0] hold_out;
        rst = 1'b1; rst4 = 1'b1;
        cmd_valid = 1'b0; cmd_a = 16'h0; cmd_b = 16'h0; cmd_fun = 4'h0; rsp_ready = 1'b1;
        cmd_valid4 = 1'b0; cmd_a4 = 16'h0; cmd_b4 = 16'h0; cmd_fun4 = 4'h0; rsp_ready4 = 1'b1;
        exp_cnt = 16'h0;
        @(posedge clk); #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        chk("rst_flag_err", 32'(rsp_flag_err), 32'd0);
        chk("rst_div0", 32'(rsp_div0), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_fun", 32'(alu_fun), 32'hF);
        rst = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;

        // Basic add, then the 1..E sweep with A=B=2.
        run_op(16'd2, 16'd2, 4'h0, 16'h0004, 4'h8, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++)
            run_op(16'd2, 16'd2, 4'(i + 1), sweep_out[i], sweep_fl[i], 1'b0, 1'b0);

        // Divide by zero answered without the ALU.
        run_op(16'd7, 16'd0, 4'h3, 16'hFFFF, 4'h8, 1'b0, 1'b1);

        // Backpressure with a competing command held during the stall.
        rsp_ready = 1'b0;
        cmd_a = 16'h0010; cmd_b = 16'h0003; cmd_fun = 4'h1; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", 32'(lat), 32'd2);
        hold_out = rsp_out;
        chk("bp_rsp_out", 32'(hold_out), 32'h000D);
        cmd_a = 16'h0005; cmd_b = 16'h0006; cmd_fun = 4'h4; cmd_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_stable", 32'(rsp_out), 32'h000D);
            chk("bp_flags_stable", 32'(rsp_flags), 32'h8);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_alu_fun", 32'(alu_fun), 32'hF);
            if (k < 5) begin @(posedge clk); #1; end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_handshake_ready", 32'(cmd_ready), 32'd1);
        chk("bp_not_yet_accepted", 32'(alu_fun), 32'hF);
        chk("bp_op_count", 32'(op_count), 32'(exp_cnt));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_new_accepted", 32'(alu_fun), 32'h4);
        chk("bp_new_busy", 32'(cmd_ready), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("bp_new_rsp_out", 32'(rsp_out), 32'h0004);
        chk("bp_new_rsp_flags", 32'(rsp_flags), 32'h4);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 16'd1;
        chk("bp_new_op_count", 32'(op_count), 32'(exp_cnt));

        // Faulty ALU raises Logic on an add.
        fault_logic = 1'b1;
        run_op(16'd2, 16'd3, 4'h0, 16'h0005, 4'h4, 1'b1, 1'b0);
        fault_logic = 1'b0;

        // Counter wrap after preloading 65535 completions.
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.op_count_q;
        @(posedge clk); #1;
        chk("wrap_preload", 32'(op_count), 32'hFFFF);
        exp_cnt = 16'hFFFF;
        run_op(16'd1, 16'd1, 4'h0, 16'h0002, 4'h8, 1'b0, 1'b0);

        // LAT=4 instance: one complete op, then reset while waiting.
        cmd_a4 = 16'd3; cmd_b4 = 16'd5; cmd_fun4 = 4'h0; cmd_valid4 = 1'b1;
        @(posedge clk); #1;
        cmd_valid4 = 1'b0;
        lat = 0;
        while (!rsp_valid4 && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("lat4_latency", 32'(lat), 32'd5);
        chk("lat4_rsp_out", 32'(rsp_out4), 32'h0008);
        @(posedge clk); #1;
        chk("lat4_op_count", 32'(op_count4), 32'd1);
        cmd_a4 = 16'd9; cmd_b4 = 16'd3; cmd_fun4 = 4'h1; cmd_valid4 = 1'b1;
        @(posedge clk); #1;
        cmd_valid4 = 1'b0;
        seen4 = rsp_valid4;
        chk("lat4_wait_fun", 32'(alu_fun4), 32'h1);
        @(posedge clk); #1;
        seen4 = seen4 | rsp_valid4;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("rst4_cmd_ready", 32'(cmd_ready4), 32'd1);
        chk("rst4_rsp_valid", 32'(rsp_valid4), 32'd0);
        chk("rst4_rsp_out", 32'(rsp_out4), 32'd0);
        chk("rst4_rsp_flags", 32'(rsp_flags4), 32'd0);
        chk("rst4_flag_err", 32'(rsp_flag_err4), 32'd0);
        chk("rst4_div0", 32'(rsp_div04), 32'd0);
        chk("rst4_op_count", 32'(op_count4), 32'd0);
        chk("rst4_alu_a", 32'(alu_a4), 32'd0);
        chk("rst4_alu_b", 32'(alu_b4), 32'd0);
        chk("rst4_alu_fun", 32'(alu_fun4), 32'hF);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            seen4 = seen4 | rsp_valid4;
            if (k == 0) chk("rst4_ready_next", 32'(cmd_ready4), 32'd1);
        end
        chk("rst4_no_response", 32'(seen4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
